// File: rtl/bus_pkg.sv
// bus_pkg: shared bus datapath constants and the select-index type used by the register file and control unit
package bus_pkg;
  localparam int WIDTH_DEF = 3;
  localparam int DEPTH_DEF = 4;
  localparam int SEL_W_DEF = $clog2(DEPTH_DEF);
  typedef logic [SEL_W_DEF-1:0] sel_t;
endpackage

// File: rtl/bus_tristate_driver.sv
// bus_tristate_driver: WIDTH-wide tristate driver, releases the bus to Z when en is low
module bus_tristate_driver #(
  parameter int WIDTH = 3
) (
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus
);
  assign bus = en ? data : 'z;
endmodule

// File: rtl/bus_regfile.sv
// bus_regfile: DEPTH x WIDTH register file on a shared tristate bus with increment port, zero flag and sticky select error
// Define BUS_REGFILE_READ_LATCH_EN to drive the bus from a read latch (1-cycle read latency).
module bus_regfile
  import bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [SEL_W-1:0] w_sel,
  input  logic             r_en,
  input  logic [SEL_W-1:0] r_sel,
  input  logic             inc_en,
  input  logic [SEL_W-1:0] inc_sel,
  inout  wire  [WIDTH-1:0] bus,
  output logic             zero,
  output logic             sel_err
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] live_val, rd_val, wdata;
  logic             rd_drive, w_ok, i_ok, r_ok;
  // Indices at or above DEPTH never match, so they read as zero and are range errors
  always_comb begin
    live_val = '0;
    w_ok     = 1'b0;
    i_ok     = 1'b0;
    r_ok     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sel == SEL_W'(i)) live_val = regs[i];
      r_ok = r_ok | (r_sel == SEL_W'(i));
      w_ok = w_ok | (w_sel == SEL_W'(i));
      i_ok = i_ok | (inc_sel == SEL_W'(i));
    end
  end
  assign zero = live_val == '0;
`ifdef BUS_REGFILE_READ_LATCH_EN
  logic             rd_en_q;
  logic [WIDTH-1:0] rd_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_en_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      rd_en_q <= r_en;
      rd_q    <= live_val;
    end
  assign rd_drive = rd_en_q;
  assign rd_val   = rd_q;
`else
  assign rd_drive = r_en;
  assign rd_val   = live_val;
`endif
  // A move takes our own read value directly rather than resolving it back off the bus
  assign wdata = rd_drive ? rd_val : bus;
  bus_tristate_driver #(.WIDTH(WIDTH)) u_drv (
    .en  (rd_drive & ~rst),
    .data(rd_val),
    .bus (bus)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      sel_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_en && w_sel == SEL_W'(i)) regs[i] <= wdata;
        else if (inc_en && inc_sel == SEL_W'(i)) regs[i] <= regs[i] + 1'b1;
      if ((w_en && !w_ok) || (inc_en && !i_ok) || (r_en && !r_ok)) sel_err <= 1'b1;
    end
endmodule
